// File: rtl/counter_bank_pkg.sv
// Shared types for the counter bank: channel count modes, config FSM states
// and the channel-index width helper.
package counter_bank_pkg;

   typedef enum logic [1:0] {
      MODE_UP_WRAP   = 2'b00,
      MODE_DOWN_WRAP = 2'b01,
      MODE_UP_SAT    = 2'b10,
      MODE_HOLD      = 2'b11
   } mode_t;

   typedef enum logic {
      CFG_READY = 1'b0,
      CFG_BUSY  = 1'b1
   } cfg_state_t;

   // A single-channel bank still needs a 1-bit index port.
   function automatic int ch_width(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/counter_channel.sv
// One counter channel: counter, step, mode and sticky wrap flag, with the
// per-mode next-state arithmetic done at CNT_W+1 bits to expose carry/borrow.
module counter_channel
   import counter_bank_pkg::*;
#(
   parameter int               CNT_W      = 16,
   parameter logic [CNT_W-1:0] RESET_CNT  = '0,
   parameter logic [CNT_W-1:0] RESET_STEP = '0
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             en,
   input  logic             cfg_we,
   input  logic [CNT_W-1:0] cfg_step,
   input  mode_t            cfg_mode,
   output logic [CNT_W-1:0] cnt,
   output logic             wrap
);

   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [CNT_W-1:0] step_q, step_d;
   mode_t            mode_q, mode_d;
   logic             wrap_q, wrap_d;
   logic [CNT_W:0]   sum;
   logic [CNT_W:0]   diff;

   assign sum  = {1'b0, cnt_q} + {1'b0, step_q};
   assign diff = {1'b0, cnt_q} - {1'b0, step_q};

   always_comb begin
      cnt_d  = cnt_q;
      step_d = step_q;
      mode_d = mode_q;
      wrap_d = wrap_q;

      // step=0 falls out naturally: no carry, no borrow, value unchanged.
      if (en) begin
         case (mode_q)
            MODE_UP_WRAP: begin
               cnt_d = sum[CNT_W-1:0];
               if (sum[CNT_W]) wrap_d = 1'b1;
            end
            MODE_DOWN_WRAP: begin
               cnt_d = diff[CNT_W-1:0];
               if (diff[CNT_W]) wrap_d = 1'b1;
            end
            MODE_UP_SAT: begin
               cnt_d = sum[CNT_W] ? {CNT_W{1'b1}} : sum[CNT_W-1:0];
            end
            default: begin
               cnt_d = cnt_q;
            end
         endcase
      end

      // The counter above still used the old step/mode; a write clears the
      // flag even when that same edge wrapped.
      if (cfg_we) begin
         step_d = cfg_step;
         mode_d = cfg_mode;
         wrap_d = 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         cnt_q  <= RESET_CNT;
         step_q <= RESET_STEP;
         mode_q <= MODE_UP_WRAP;
         wrap_q <= 1'b0;
      end else begin
         cnt_q  <= cnt_d;
         step_q <= step_d;
         mode_q <= mode_d;
         wrap_q <= wrap_d;
      end
   end

   assign cnt  = cnt_q;
   assign wrap = wrap_q;

endmodule

// File: rtl/param_counter_bank.sv
// Bank of NUM_CH programmable free-running counters with a one-write-per-two-
// cycles config port, a registered snapshot read port, taps and wrap flags.
module param_counter_bank
   import counter_bank_pkg::*;
#(
   parameter int    NUM_CH    = 16,
   parameter int    CNT_W     = 16,
   parameter int    STEP_BASE = 10000,
   parameter int    TAP_BIT   = CNT_W - 1,
   localparam int   CH_W      = ch_width(NUM_CH)
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              en,
   input  logic              cfg_valid,
   output logic              cfg_ready,
   input  logic [CH_W-1:0]   cfg_ch,
   input  logic [CNT_W-1:0]  cfg_step,
   input  logic [1:0]        cfg_mode,
   input  logic              snap_req,
   input  logic [CH_W-1:0]   snap_ch,
   output logic              snap_valid,
   output logic [CNT_W-1:0]  snap_data,
   output logic [NUM_CH-1:0] taps,
   output logic [NUM_CH-1:0] wrap_flags
);

   cfg_state_t       state_q, state_d;
   logic             cfg_ready_q, cfg_ready_d;
   logic             cfg_accept;
   logic [NUM_CH-1:0] ch_we;
   logic [CNT_W-1:0] cnt_all [NUM_CH];
   logic [CNT_W-1:0] snap_sel;
   logic             snap_valid_q, snap_valid_d;
   logic [CNT_W-1:0] snap_data_q, snap_data_d;

   assign cfg_accept = cfg_valid && cfg_ready_q;

   always_comb begin
      state_d     = state_q;
      cfg_ready_d = cfg_ready_q;
      case (state_q)
         CFG_READY: begin
            if (cfg_accept) begin
               state_d     = CFG_BUSY;
               cfg_ready_d = 1'b0;
            end
         end
         default: begin
            state_d     = CFG_READY;
            cfg_ready_d = 1'b1;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= CFG_READY;
         cfg_ready_q <= 1'b1;
      end else begin
         state_q     <= state_d;
         cfg_ready_q <= cfg_ready_d;
      end
   end

   genvar gi;
   generate
      for (gi = 0; gi < NUM_CH; gi++) begin : gen_ch
         localparam logic [CNT_W-1:0] RST_CNT  = CNT_W'(gi);
         localparam logic [CNT_W-1:0] RST_STEP = CNT_W'(STEP_BASE * gi);

         // Out-of-range channel indices match no channel, so they are dropped.
         assign ch_we[gi] = cfg_accept && (cfg_ch == CH_W'(gi));

         counter_channel #(
            .CNT_W      (CNT_W),
            .RESET_CNT  (RST_CNT),
            .RESET_STEP (RST_STEP)
         ) u_ch (
            .clk      (clk),
            .rst      (rst),
            .en       (en),
            .cfg_we   (ch_we[gi]),
            .cfg_step (cfg_step),
            .cfg_mode (mode_t'(cfg_mode)),
            .cnt      (cnt_all[gi]),
            .wrap     (wrap_flags[gi])
         );

         assign taps[gi] = cnt_all[gi][TAP_BIT];
      end
   endgenerate

   always_comb begin
      snap_sel = '0;
      for (int i = 0; i < NUM_CH; i++) begin
         if (snap_ch == CH_W'(i)) snap_sel = cnt_all[i];
      end
   end

   always_comb begin
      snap_valid_d = snap_req;
      snap_data_d  = snap_req ? snap_sel : snap_data_q;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         snap_valid_q <= 1'b0;
         snap_data_q  <= '0;
      end else begin
         snap_valid_q <= snap_valid_d;
         snap_data_q  <= snap_data_d;
      end
   end

   assign cfg_ready  = cfg_ready_q;
   assign snap_valid = snap_valid_q;
   assign snap_data  = snap_data_q;

endmodule

// File: tb/tb_param_counter_bank.sv
// Directed bench for param_counter_bank: a 16-channel instance for the main
// behaviour and a 12-channel instance to reach out-of-range channel indices.
module tb_param_counter_bank;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic        en = 1'b0;
   logic        cfg_valid = 1'b0;
   logic [3:0]  cfg_ch = '0;
   logic [15:0] cfg_step = '0;
   logic [1:0]  cfg_mode = '0;
   logic        snap_req = 1'b0;
   logic [3:0]  snap_ch = '0;
   logic        cfg_ready, snap_valid;
   logic [15:0] snap_data, taps, wrap_flags;

   logic        b_cfg_valid = 1'b0;
   logic [3:0]  b_cfg_ch = '0;
   logic [15:0] b_cfg_step = '0;
   logic [1:0]  b_cfg_mode = '0;
   logic        b_snap_req = 1'b0;
   logic [3:0]  b_snap_ch = '0;
   logic        b_cfg_ready, b_snap_valid;
   logic [15:0] b_snap_data;
   logic [11:0] b_taps, b_wrap_flags;

   int cmp_cnt = 0;
   int err_cnt = 0;

   always #5 clk = ~clk;

   param_counter_bank #(.NUM_CH(16), .CNT_W(16), .STEP_BASE(10000)) dut (
      .clk(clk), .rst(rst), .en(en),
      .cfg_valid(cfg_valid), .cfg_ready(cfg_ready), .cfg_ch(cfg_ch),
      .cfg_step(cfg_step), .cfg_mode(cfg_mode),
      .snap_req(snap_req), .snap_ch(snap_ch), .snap_valid(snap_valid),
      .snap_data(snap_data), .taps(taps), .wrap_flags(wrap_flags)
   );

   param_counter_bank #(.NUM_CH(12), .CNT_W(16), .STEP_BASE(10000)) dut_b (
      .clk(clk), .rst(rst), .en(en),
      .cfg_valid(b_cfg_valid), .cfg_ready(b_cfg_ready), .cfg_ch(b_cfg_ch),
      .cfg_step(b_cfg_step), .cfg_mode(b_cfg_mode),
      .snap_req(b_snap_req), .snap_ch(b_snap_ch), .snap_valid(b_snap_valid),
      .snap_data(b_snap_data), .taps(b_taps), .wrap_flags(b_wrap_flags)
   );

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset;
      rst = 1'b1;
      tick();
      rst = 1'b0;
   endtask

   task automatic cfg_write(input logic [3:0] ch, input logic [15:0] step, input logic [1:0] mode);
      if (!cfg_ready) tick();
      cfg_valid = 1'b1;
      cfg_ch    = ch;
      cfg_step  = step;
      cfg_mode  = mode;
      tick();
      cfg_valid = 1'b0;
      $display("cfg write ch=%0d step=%h mode=%0d", ch, step, mode);
   endtask

   task automatic do_snap(input logic [3:0] ch);
      snap_req = 1'b1;
      snap_ch  = ch;
      tick();
      snap_req = 1'b0;
      $display("snapshot ch=%0d -> valid=%b data=%0d", ch, snap_valid, snap_data);
   endtask

   task automatic test_reset;
      en = 1'b0;
      do_reset();
      cmp_cnt++; if (cfg_ready !== 1'b1) begin err_cnt++; $display("FAIL rst_cfg_ready: got %b want 1", cfg_ready); end
      cmp_cnt++; if (snap_valid !== 1'b0) begin err_cnt++; $display("FAIL rst_snap_valid: got %b want 0", snap_valid); end
      cmp_cnt++; if (snap_data !== 16'd0) begin err_cnt++; $display("FAIL rst_snap_data: got %0d want 0", snap_data); end
      cmp_cnt++; if (wrap_flags !== 16'h0000) begin err_cnt++; $display("FAIL rst_flags: got %h want 0000", wrap_flags); end
      cmp_cnt++; if (taps !== 16'h0000) begin err_cnt++; $display("FAIL rst_taps: got %h want 0000", taps); end
      en = 1'b1;
      tick();
      en = 1'b0;
      cmp_cnt++; if (taps !== 16'h3C70) begin err_cnt++; $display("FAIL count1_taps: got %h want 3c70", taps); end
      cmp_cnt++; if (wrap_flags !== 16'h0000) begin err_cnt++; $display("FAIL count1_flags: got %h want 0000", wrap_flags); end
      do_snap(4'd3);
      cmp_cnt++; if (snap_valid !== 1'b1) begin err_cnt++; $display("FAIL count1_valid3: got %b want 1", snap_valid); end
      cmp_cnt++; if (snap_data !== 16'd30003) begin err_cnt++; $display("FAIL count1_ch3: got %0d want 30003", snap_data); end
      do_snap(4'd7);
      cmp_cnt++; if (snap_data !== 16'd4471) begin err_cnt++; $display("FAIL count1_ch7: got %0d want 4471", snap_data); end
      tick();
      cmp_cnt++; if (snap_valid !== 1'b0) begin err_cnt++; $display("FAIL snap_pulse: got %b want 0", snap_valid); end
      cmp_cnt++; if (snap_data !== 16'd4471) begin err_cnt++; $display("FAIL snap_hold: got %0d want 4471", snap_data); end
   endtask

   task automatic test_snapshot;
      en = 1'b1;
      do_reset();
      tick();
      do_snap(4'd3);
      cmp_cnt++; if (snap_valid !== 1'b1) begin err_cnt++; $display("FAIL snap_e2_valid: got %b want 1", snap_valid); end
      cmp_cnt++; if (snap_data !== 16'd30003) begin err_cnt++; $display("FAIL snap_e2_ch3: got %0d want 30003", snap_data); end
      do_snap(4'd7);
      cmp_cnt++; if (snap_valid !== 1'b1) begin err_cnt++; $display("FAIL snap_e3_valid: got %b want 1", snap_valid); end
      cmp_cnt++; if (snap_data !== 16'd8935) begin err_cnt++; $display("FAIL snap_e3_ch7: got %0d want 8935", snap_data); end
      en = 1'b0;
      tick();
      cmp_cnt++; if (snap_valid !== 1'b0) begin err_cnt++; $display("FAIL snap_e4_valid: got %b want 0", snap_valid); end
   endtask

   task automatic test_wrap;
      en = 1'b0;
      do_reset();
      cfg_write(4'd1, 16'h8000, 2'b00);
      cmp_cnt++; if (cfg_ready !== 1'b0) begin err_cnt++; $display("FAIL wrap_ready_drop: got %b want 0", cfg_ready); end
      en = 1'b1;
      tick();
      $display("wrap count 1 taps=%h flags=%h", taps, wrap_flags);
      cmp_cnt++; if (taps[1] !== 1'b1) begin err_cnt++; $display("FAIL wrap_tap1_hi: got %b want 1", taps[1]); end
      cmp_cnt++; if (wrap_flags !== 16'h0000) begin err_cnt++; $display("FAIL wrap_flags1: got %h want 0000", wrap_flags); end
      cmp_cnt++; if (cfg_ready !== 1'b1) begin err_cnt++; $display("FAIL wrap_ready_back: got %b want 1", cfg_ready); end
      tick();
      en = 1'b0;
      $display("wrap count 2 taps=%h flags=%h", taps, wrap_flags);
      cmp_cnt++; if (taps[1] !== 1'b0) begin err_cnt++; $display("FAIL wrap_tap1_lo: got %b want 0", taps[1]); end
      cmp_cnt++; if (wrap_flags !== 16'h3C72) begin err_cnt++; $display("FAIL wrap_flags2: got %h want 3c72", wrap_flags); end
      do_snap(4'd1);
      cmp_cnt++; if (snap_data !== 16'h0001) begin err_cnt++; $display("FAIL wrap_ch1: got %h want 0001", snap_data); end
   endtask

   task automatic test_handshake;
      logic [3:0]  hc [4];
      logic [15:0] hs [4];
      logic [1:0]  hm [4];
      logic        hr [4];
      logic [15:0] hf [4];
      hc = '{4'd10, 4'd13, 4'd1, 4'd12};
      hs = '{16'd34464, 16'd0, 16'h0100, 16'd0};
      hm = '{2'b00, 2'b11, 2'b11, 2'b11};
      hr = '{1'b1, 1'b0, 1'b1, 1'b0};
      hf = '{16'h3872, 16'h3872, 16'h3870, 16'h3870};
      en = 1'b0;
      for (int k = 0; k < 4; k++) begin
         cfg_valid = 1'b1;
         cfg_ch    = hc[k];
         cfg_step  = hs[k];
         cfg_mode  = hm[k];
         cmp_cnt++; if (cfg_ready !== hr[k]) begin err_cnt++; $display("FAIL hs_ready[%0d]: got %b want %b", k, cfg_ready, hr[k]); end
         tick();
         $display("handshake cycle %0d ch=%0d flags=%h", k, hc[k], wrap_flags);
         cmp_cnt++; if (wrap_flags !== hf[k]) begin err_cnt++; $display("FAIL hs_flags[%0d]: got %h want %h", k, wrap_flags, hf[k]); end
      end
      cfg_valid = 1'b0;
      en = 1'b1;
      tick();
      en = 1'b0;
      do_snap(4'd1);
      cmp_cnt++; if (snap_data !== 16'd1) begin err_cnt++; $display("FAIL hs_hold_ch1: got %0d want 1", snap_data); end
      do_snap(4'd10);
      cmp_cnt++; if (snap_data !== 16'd37866) begin err_cnt++; $display("FAIL hs_ch10: got %0d want 37866", snap_data); end
      do_snap(4'd13);
      cmp_cnt++; if (snap_data !== 16'd62333) begin err_cnt++; $display("FAIL hs_ch13: got %0d want 62333", snap_data); end
   endtask

   task automatic test_down_sat;
      en = 1'b0;
      do_reset();
      cfg_write(4'd0, 16'd1, 2'b01);
      cfg_write(4'd15, 16'hFFFF, 2'b10);
      en = 1'b1;
      tick();
      $display("down/sat count 1 taps=%h flags=%h", taps, wrap_flags);
      cmp_cnt++; if (wrap_flags !== 16'h0001) begin err_cnt++; $display("FAIL ds_flags1: got %h want 0001", wrap_flags); end
      cmp_cnt++; if (taps !== 16'hBC71) begin err_cnt++; $display("FAIL ds_taps1: got %h want bc71", taps); end
      tick();
      en = 1'b0;
      $display("down/sat count 2 taps=%h flags=%h", taps, wrap_flags);
      cmp_cnt++; if (wrap_flags !== 16'h3C71) begin err_cnt++; $display("FAIL ds_flags2: got %h want 3c71", wrap_flags); end
      do_snap(4'd15);
      cmp_cnt++; if (snap_data !== 16'hFFFF) begin err_cnt++; $display("FAIL ds_sat_ch15: got %h want ffff", snap_data); end
      do_snap(4'd0);
      cmp_cnt++; if (snap_data !== 16'hFFFE) begin err_cnt++; $display("FAIL ds_down_ch0: got %h want fffe", snap_data); end
      // ch5 wraps on this edge while being rewritten: the clear must win.
      en        = 1'b1;
      cfg_valid = 1'b1;
      cfg_ch    = 4'd5;
      cfg_step  = 16'd50000;
      cfg_mode  = 2'b00;
      tick();
      en        = 1'b0;
      cfg_valid = 1'b0;
      $display("clear-vs-wrap ch5 flags=%h", wrap_flags);
      cmp_cnt++; if (wrap_flags[5] !== 1'b0) begin err_cnt++; $display("FAIL ds_clear_wins: got %b want 0", wrap_flags[5]); end
      do_snap(4'd5);
      cmp_cnt++; if (snap_data !== 16'd18933) begin err_cnt++; $display("FAIL ds_old_step_ch5: got %0d want 18933", snap_data); end
   endtask

   task automatic test_reset_midop;
      en        = 1'b1;
      cfg_valid = 1'b1;
      cfg_ch    = 4'd2;
      cfg_step  = 16'd7;
      cfg_mode  = 2'b01;
      tick();
      cfg_valid = 1'b0;
      rst       = 1'b1;
      snap_req  = 1'b1;
      snap_ch   = 4'd3;
      tick();
      rst      = 1'b0;
      snap_req = 1'b0;
      en       = 1'b0;
      $display("reset mid-op ready=%b valid=%b flags=%h taps=%h", cfg_ready, snap_valid, wrap_flags, taps);
      cmp_cnt++; if (snap_valid !== 1'b0) begin err_cnt++; $display("FAIL mid_snap_valid: got %b want 0", snap_valid); end
      cmp_cnt++; if (snap_data !== 16'd0) begin err_cnt++; $display("FAIL mid_snap_data: got %0d want 0", snap_data); end
      cmp_cnt++; if (cfg_ready !== 1'b1) begin err_cnt++; $display("FAIL mid_cfg_ready: got %b want 1", cfg_ready); end
      cmp_cnt++; if (wrap_flags !== 16'h0000) begin err_cnt++; $display("FAIL mid_flags: got %h want 0000", wrap_flags); end
      cmp_cnt++; if (taps !== 16'h0000) begin err_cnt++; $display("FAIL mid_taps: got %h want 0000", taps); end
      do_snap(4'd2);
      cmp_cnt++; if (snap_data !== 16'd2) begin err_cnt++; $display("FAIL mid_ch2: got %0d want 2", snap_data); end
      do_snap(4'd15);
      cmp_cnt++; if (snap_data !== 16'd15) begin err_cnt++; $display("FAIL mid_ch15: got %0d want 15", snap_data); end
      en = 1'b1;
      tick();
      en = 1'b0;
      do_snap(4'd2);
      cmp_cnt++; if (snap_data !== 16'd20002) begin err_cnt++; $display("FAIL mid_ch2_step: got %0d want 20002", snap_data); end
   endtask

   task automatic test_out_of_range;
      en = 1'b0;
      do_reset();
      b_cfg_valid = 1'b1;
      b_cfg_ch    = 4'd13;
      b_cfg_step  = 16'd0;
      b_cfg_mode  = 2'b11;
      cmp_cnt++; if (b_cfg_ready !== 1'b1) begin err_cnt++; $display("FAIL oor_ready_pre: got %b want 1", b_cfg_ready); end
      tick();
      b_cfg_valid = 1'b0;
      $display("oor cfg ch=13 ready=%b flags=%h", b_cfg_ready, b_wrap_flags);
      cmp_cnt++; if (b_cfg_ready !== 1'b0) begin err_cnt++; $display("FAIL oor_ready_drop: got %b want 0", b_cfg_ready); end
      cmp_cnt++; if (b_wrap_flags !== 12'h000) begin err_cnt++; $display("FAIL oor_flags: got %h want 000", b_wrap_flags); end
      tick();
      cmp_cnt++; if (b_cfg_ready !== 1'b1) begin err_cnt++; $display("FAIL oor_ready_back: got %b want 1", b_cfg_ready); end
      b_snap_req = 1'b1;
      b_snap_ch  = 4'd5;
      tick();
      $display("oor snapshot ch=5 valid=%b data=%0d", b_snap_valid, b_snap_data);
      cmp_cnt++; if (b_snap_data !== 16'd5) begin err_cnt++; $display("FAIL oor_ch5: got %0d want 5", b_snap_data); end
      b_snap_ch = 4'd14;
      tick();
      b_snap_req = 1'b0;
      $display("oor snapshot ch=14 valid=%b data=%0d", b_snap_valid, b_snap_data);
      cmp_cnt++; if (b_snap_valid !== 1'b1) begin err_cnt++; $display("FAIL oor_valid14: got %b want 1", b_snap_valid); end
      cmp_cnt++; if (b_snap_data !== 16'd0) begin err_cnt++; $display("FAIL oor_data14: got %0d want 0", b_snap_data); end
      en = 1'b1;
      tick();
      en = 1'b0;
      b_snap_req = 1'b1;
      b_snap_ch  = 4'd11;
      tick();
      b_snap_req = 1'b0;
      cmp_cnt++; if (b_snap_data !== 16'd44475) begin err_cnt++; $display("FAIL oor_ch11: got %0d want 44475", b_snap_data); end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   initial begin
      tick();
      test_reset();
      test_snapshot();
      test_wrap();
      test_handshake();
      test_down_sat();
      test_reset_midop();
      test_out_of_range();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_cnt, err_cnt);
      $finish;
   end

endmodule
